// File: rtl/hazard_fwd_unit.sv
// Hazard detection and operand forwarding beside decode: tracks in-flight
// destinations over STAGES downstream entries, forwards operands, raises stalls.
module hazard_fwd_unit #(
  parameter int ADDR_LINE_REG = 5,
  parameter int D_SIZE        = 32,
  parameter int STAGES        = 3,
  parameter int FWD_EN        = 1,
  localparam int SEL_W        = $clog2(STAGES + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     id_valid,
  input  logic [ADDR_LINE_REG-1:0] id_rs,
  input  logic [ADDR_LINE_REG-1:0] id_rt,
  input  logic                     id_rs_used,
  input  logic                     id_rt_used,
  input  logic [ADDR_LINE_REG-1:0] id_dest,
  input  logic                     id_reg_write,
  input  logic                     id_is_load,
  input  logic                     flush,
  input  logic [D_SIZE-1:0]        rs_data_in,
  input  logic [D_SIZE-1:0]        rt_data_in,
  input  logic [STAGES*D_SIZE-1:0] stage_data,
  output logic                     stall,
  output logic [SEL_W-1:0]         fwd_rs_sel,
  output logic [SEL_W-1:0]         fwd_rt_sel,
  output logic [D_SIZE-1:0]        rs_data_out,
  output logic [D_SIZE-1:0]        rt_data_out,
  output logic [STAGES-1:0]        inflight,
  output logic [15:0]              stall_cnt
);

  logic [STAGES-1:0]        valid_q, valid_d;
  logic [STAGES-1:0]        wr_q, wr_d;
  logic [STAGES-1:0]        load_q, load_d;
  logic [ADDR_LINE_REG-1:0] dest_q [STAGES];
  logic [ADDR_LINE_REG-1:0] dest_d [STAGES];
  logic [15:0]              stall_cnt_q, stall_cnt_d;

  logic [STAGES-1:0] rs_hit, rt_hit;
  logic [SEL_W-1:0]  rs_sel, rt_sel;
  logic [D_SIZE-1:0] rs_fwd, rt_fwd;
  logic              hazard;

  always_comb begin
    rs_hit = '0;
    rt_hit = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      rs_hit[k] = id_rs_used && valid_q[k] && wr_q[k] && (dest_q[k] == id_rs) && (id_rs != '0);
      rt_hit[k] = id_rt_used && valid_q[k] && wr_q[k] && (dest_q[k] == id_rt) && (id_rt != '0);
    end
  end

  // Scan oldest to youngest so the youngest (lowest-index) match wins.
  always_comb begin
    rs_sel = '0;
    rt_sel = '0;
    rs_fwd = rs_data_in;
    rt_fwd = rt_data_in;
    for (int unsigned i = 0; i < STAGES; i++) begin
      if (rs_hit[STAGES-1-i]) begin
        rs_sel = SEL_W'(STAGES - i);
        rs_fwd = stage_data[(STAGES-1-i)*D_SIZE +: D_SIZE];
      end
      if (rt_hit[STAGES-1-i]) begin
        rt_sel = SEL_W'(STAGES - i);
        rt_fwd = stage_data[(STAGES-1-i)*D_SIZE +: D_SIZE];
      end
    end
  end

  always_comb begin
    if (FWD_EN != 0) begin
      hazard = load_q[0] && (rs_hit[0] || rt_hit[0]);
    end else begin
      hazard = (|rs_hit) || (|rt_hit);
    end
    stall = id_valid && !flush && !reset && hazard;

    fwd_rs_sel  = '0;
    fwd_rt_sel  = '0;
    rs_data_out = rs_data_in;
    rt_data_out = rt_data_in;
    if (FWD_EN != 0 && !reset) begin
      fwd_rs_sel  = rs_sel;
      fwd_rt_sel  = rt_sel;
      rs_data_out = rs_fwd;
      rt_data_out = rt_fwd;
    end
    inflight  = reset ? '0 : valid_q;
    stall_cnt = stall_cnt_q;
  end

  always_comb begin
    valid_d[0] = id_valid && !stall && !flush;
    wr_d[0]    = id_reg_write;
    load_d[0]  = id_is_load;
    dest_d[0]  = id_dest;
    for (int unsigned k = 1; k < STAGES; k++) begin
      valid_d[k] = valid_q[k-1];
      wr_d[k]    = wr_q[k-1];
      load_d[k]  = load_q[k-1];
      dest_d[k]  = dest_q[k-1];
    end
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= '0;
      wr_q        <= '0;
      load_q      <= '0;
      stall_cnt_q <= '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        dest_q[k] <= '0;
      end
    end else begin
      valid_q     <= valid_d;
      wr_q        <= wr_d;
      load_q      <= load_d;
      stall_cnt_q <= stall_cnt_d;
      for (int unsigned k = 0; k < STAGES; k++) begin
        dest_q[k] <= dest_d[k];
      end
    end
  end

endmodule

// File: doc/hazard_fwd_unit.md
# hazard_fwd_unit

Parametrised hazard-detection and operand-forwarding unit for the 5-stage core. It sits beside decode and tracks the destination registers of instructions in flight over a configurable number of downstream stages. It selects forwarded operand data for decode and raises a stall for unresolvable dependencies. It replaces the fixed three-destination compare inside fetch and adds a forwarding mode, load-use detection, flush handling and a stall counter.

## Interface
Parameters:
- ADDR_LINE_REG, 5, register address width
- D_SIZE, 32, data width
- STAGES, 3, tracked in-flight stages: entry 0 = EX, entry STAGES-1 = WB; minimum 2
- FWD_EN, 1, 1 = forward and stall only on load-use; 0 = stall-only mode

Ports (SEL_W = $clog2(STAGES+1)):
- clk  in  1  clock; one clock, all state on rising edge
- reset  in  1  synchronous, active-high
- id_valid  in  1  decode holds a valid instruction
- id_rs, id_rt  in  ADDR_LINE_REG  source register addresses
- id_rs_used, id_rt_used  in  1  source actually read
- id_dest  in  ADDR_LINE_REG  destination address
- id_reg_write  in  1  instruction writes id_dest
- id_is_load  in  1  instruction is a load
- flush  in  1  taken branch resolved; kill decode instruction
- rs_data_in, rt_data_in  in  D_SIZE  register file read data
- stage_data  in  STAGES*D_SIZE  result of entry k at [k*D_SIZE +: D_SIZE]
- stall  out  1  hold PC and IF/ID, inject bubble
- fwd_rs_sel, fwd_rt_sel  out  SEL_W  0 = register file, k+1 = entry k
- rs_data_out, rt_data_out  out  D_SIZE  selected operand data
- inflight  out  STAGES  valid bit of each entry
- stall_cnt  out  16  stall-cycle counter, saturating

## Operation
- State: shift register of STAGES entries {valid, dest, reg_write, is_load}.
- Each rising edge: entry[k] <= entry[k-1] for k >= 1. entry[0] <= decode instruction if id_valid & !stall & !flush. Otherwise entry[0] <= bubble (valid=0).
- Match on entry k for a source: source used, entry valid, reg_write=1, dest == source, dest != 0. Register 0 never matches.
- FWD_EN=1:
  - The selected entry is the lowest-index (youngest) match, giving sel = k+1 and data = stage_data[k].
  - With no match, sel = 0 and data = register file data.
  - stall = 1 when the youngest match for either source is entry 0 with is_load=1, because load data first exists at entry 1.
- FWD_EN=0:
  - sel is always 0 and data is always register file data.
  - stall = 1 on any match in any entry.
- stall is forced to 0 when id_valid=0 or flush=1. Flush takes priority over stall.
- stall_cnt increments on each cycle with stall=1 and saturates at 16'hFFFF.
- inflight[k] = entry[k].valid.

## Timing
- stall, fwd_*_sel and *_data_out are combinational from inputs and current entries, valid in the same cycle.
- Entry state updates on the rising clk edge only.
- Reset (synchronous, any cycle including mid-stall) clears all entries to valid=0 and sets stall_cnt to 0. In the reset cycle and the cycle after, stall=0, sel=0, *_data_out = *_data_in and inflight=0.
- Load-use penalty:
  - FWD_EN=1: exactly 1 cycle. On the next cycle the load sits in entry 1, giving sel=2 and no stall.
  - FWD_EN=0: the dependent instruction stalls until the producer leaves entry STAGES-1, which is STAGES cycles when issued back-to-back.
- Simultaneous stall condition and flush: no stall, bubble enters entry 0, and stall_cnt does not increment.
- Both sources matching different entries: each source resolves independently. stall is the OR of both.

## Test plan
- FWD_EN=1, STAGES=3: issue ADD r3 (entry 0, stage_data[0]=32'h42), then decode SUB reads rs=r3 -> stall=0, fwd_rs_sel=1, rs_data_out=32'h42.
- Load r5 then dependent use of r5 -> stall=1 for one cycle and stall_cnt=1. Next cycle stall=0, fwd_rs_sel=2, rs_data_out=stage_data[1].
- Writer with id_dest=r0, then a reader of r0 -> stall=0, sel=0, data = rs_data_in.
- Load-use hazard with flush=1 in the same cycle -> stall=0, inflight[0]=0 next cycle, stall_cnt unchanged.
- FWD_EN=0, STAGES=3: ADD r7 followed by a reader of r7 -> stall=1 for 3 consecutive cycles, then 0, and stall_cnt=3.
- r4 written by entries 0 and 2 (stage_data[0]=32'h11, stage_data[2]=32'h22) -> fwd_rs_sel=1, rs_data_out=32'h11. Assert reset mid-stall -> all outputs return to reset values next cycle.
